// File: rtl/simple_nios2_system_pll_seq.sv
// Post-PLL lock qualifier: synchronises and filters the raw lock flag, releases per-channel
// resets in a staggered sequence, generates divided clock enables and records lock losses.
module simple_nios2_system_pll_seq #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 256,
    parameter int RST_STAGGER = 16
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic [NUM_CH*CNT_W-1:0] div_ratio,
    input  logic [NUM_CH*CNT_W-1:0] phase_ofs,
    input  logic                    clr_lost,
    output logic                    locked,
    output logic [NUM_CH-1:0]       ch_rst,
    output logic [NUM_CH-1:0]       ch_en,
    output logic                    lock_lost,
    output logic [7:0]              loss_count
);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        FILTER,
        RELEASE,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0]  FILT_LAST   = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]  STAG_LAST   = CNT_W'(RST_STAGGER - 1);
    localparam logic [NUM_CH-1:0] ALL_RST     = {NUM_CH{1'b1}};
    // Reset pattern on the first qualified-lock cycle: only channel 0 released.
    localparam logic [NUM_CH-1:0] FIRST_REL   = ALL_RST << 1;
    localparam bit                DIRECT_LOCK = (LOCK_FILTER == 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   lock_s;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       filt_reg, filt_next;
    logic [CNT_W-1:0]       stag_reg, stag_next;
    logic [NUM_CH-1:0]      ch_rst_reg, ch_rst_next;
    logic [NUM_CH-1:0]      ch_rst_shift;
    logic                   lock_lost_reg, lock_lost_next;
    logic [7:0]             loss_count_reg, loss_count_next;
    logic                   loss_event;

    assign lock_s       = sync_reg[SYNC_STAGES-1];
    assign ch_rst_shift = ch_rst_reg << 1;

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_reg       <= '0;
            state_reg      <= WAIT_LOCK;
            filt_reg       <= '0;
            stag_reg       <= '0;
            ch_rst_reg     <= ALL_RST;
            lock_lost_reg  <= 1'b0;
            loss_count_reg <= '0;
        end else begin
            sync_reg       <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
            state_reg      <= state_next;
            filt_reg       <= filt_next;
            stag_reg       <= stag_next;
            ch_rst_reg     <= ch_rst_next;
            lock_lost_reg  <= lock_lost_next;
            loss_count_reg <= loss_count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        filt_next   = filt_reg;
        stag_next   = stag_reg;
        ch_rst_next = ch_rst_reg;
        loss_event  = 1'b0;

        case (state_reg)
            WAIT_LOCK: begin
                ch_rst_next = ALL_RST;
                filt_next   = '0;
                stag_next   = '0;
                if (lock_s) begin
                    if (DIRECT_LOCK) begin
                        ch_rst_next = FIRST_REL;
                        state_next  = (FIRST_REL == '0) ? RUN : RELEASE;
                    end else begin
                        filt_next  = CNT_W'(1);
                        state_next = FILTER;
                    end
                end
            end
            FILTER: begin
                // A dropout while filtering simply restarts qualification.
                if (!lock_s) begin
                    filt_next  = '0;
                    state_next = WAIT_LOCK;
                end else if (filt_reg == FILT_LAST) begin
                    filt_next   = '0;
                    stag_next   = '0;
                    ch_rst_next = FIRST_REL;
                    state_next  = (FIRST_REL == '0) ? RUN : RELEASE;
                end else begin
                    filt_next = filt_reg + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    loss_event  = 1'b1;
                    stag_next   = '0;
                    ch_rst_next = ALL_RST;
                    state_next  = WAIT_LOCK;
                end else if (stag_reg == STAG_LAST) begin
                    stag_next   = '0;
                    ch_rst_next = ch_rst_shift;
                    if (ch_rst_shift == '0) begin
                        state_next = RUN;
                    end
                end else begin
                    stag_next = stag_reg + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    loss_event  = 1'b1;
                    stag_next   = '0;
                    ch_rst_next = ALL_RST;
                    state_next  = WAIT_LOCK;
                end
            end
            default: begin
                ch_rst_next = ALL_RST;
                state_next  = WAIT_LOCK;
            end
        endcase
    end

    // A new loss outranks a simultaneous clear so no event is ever missed.
    always_comb begin
        lock_lost_next  = loss_event | (lock_lost_reg & ~clr_lost);
        loss_count_next = loss_count_reg;
        if (loss_event && (loss_count_reg != 8'hFF)) begin
            loss_count_next = loss_count_reg + 8'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] div_i;
            logic [CNT_W-1:0] phase_i;
            logic [CNT_W-1:0] reload_val;

            assign div_i      = div_ratio[gi*CNT_W +: CNT_W];
            assign phase_i    = phase_ofs[gi*CNT_W +: CNT_W];
            assign reload_val = (div_i == '0) ? '0 : div_i - CNT_W'(1);

            // The counter loads phase_ofs on the edge that releases the channel reset,
            // so the first enabled cycle already sees the initial delay.
            always_ff @(posedge refclk) begin
                if (rst || ch_rst_next[gi]) begin
                    cnt_reg <= '0;
                end else if (ch_rst_reg[gi]) begin
                    cnt_reg <= phase_i;
                end else if (cnt_reg == '0) begin
                    cnt_reg <= reload_val;
                end else begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end

            assign ch_en[gi] = (cnt_reg == '0) & ~ch_rst_reg[gi];
        end
    endgenerate

    assign locked     = (state_reg == RELEASE) || (state_reg == RUN);
    assign ch_rst     = ch_rst_reg;
    assign lock_lost  = lock_lost_reg;
    assign loss_count = loss_count_reg;

endmodule

// File: tb/tb_simple_nios2_system_pll_seq.sv
// Directed bench: default-parameter instance for lock/release/divider timing, plus a
// single-channel short-filter instance for loss counting and sticky-flag behaviour.
module tb_simple_nios2_system_pll_seq;

    logic        refclk;
    logic        rst;
    logic        pll_locked;
    logic [31:0] div_ratio;
    logic [31:0] phase_ofs;
    logic        clr_lost;
    logic        locked;
    logic [1:0]  ch_rst;
    logic [1:0]  ch_en;
    logic        lock_lost;
    logic [7:0]  loss_count;

    logic        pll2;
    logic [7:0]  div2;
    logic [7:0]  phase2;
    logic        clr2;
    logic        locked2;
    logic        ch_rst2;
    logic        ch_en2;
    logic        lock_lost2;
    logic [7:0]  loss2;

    int cyc;
    int n_checks;
    int n_errors;
    int b;

    simple_nios2_system_pll_seq u_dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .div_ratio  (div_ratio),
        .phase_ofs  (phase_ofs),
        .clr_lost   (clr_lost),
        .locked     (locked),
        .ch_rst     (ch_rst),
        .ch_en      (ch_en),
        .lock_lost  (lock_lost),
        .loss_count (loss_count)
    );

    simple_nios2_system_pll_seq #(
        .NUM_CH      (1),
        .CNT_W       (8),
        .SYNC_STAGES (2),
        .LOCK_FILTER (2),
        .RST_STAGGER (1)
    ) u_dut2 (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll2),
        .div_ratio  (div2),
        .phase_ofs  (phase2),
        .clr_lost   (clr2),
        .locked     (locked2),
        .ch_rst     (ch_rst2),
        .ch_en      (ch_en2),
        .lock_lost  (lock_lost2),
        .loss_count (loss2)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end else begin
            $display("check %s @cyc %0d: got %0h ok", tag, cyc, got);
        end
    endtask

    // Advance n cycles; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
            cyc++;
        end
    endtask

    task automatic go_to(input int t);
        step(t - cyc);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;
        clr_lost   = 1'b0;
        div_ratio  = {16'd3, 16'd4};
        phase_ofs  = {16'd0, 16'd2};
        pll2       = 1'b0;
        clr2       = 1'b0;
        div2       = 8'd1;
        phase2     = 8'd0;

        step(3);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_ch_rst", 32'(ch_rst), 32'h3);
        check_val("rst_ch_en", 32'(ch_en), 32'h0);
        check_val("rst_lock_lost", 32'(lock_lost), 32'd0);
        check_val("rst_loss_count", 32'(loss_count), 32'd0);

        // Cycle 0: lock rises and stays.
        rst        = 1'b0;
        pll_locked = 1'b1;
        cyc        = 0;

        go_to(257);
        check_val("locked_before", 32'(locked), 32'd0);
        go_to(258);
        check_val("locked_at_T", 32'(locked), 32'd1);
        check_val("ch_rst_at_T", 32'(ch_rst), 32'h2);
        check_val("ch_en_at_T", 32'(ch_en), 32'h0);
        go_to(260);
        check_val("en0_first", 32'(ch_en), 32'h1);
        go_to(264);
        check_val("en0_second", 32'(ch_en), 32'h1);
        go_to(273);
        check_val("ch1_still_rst", 32'(ch_rst), 32'h2);
        go_to(274);
        check_val("ch1_release", 32'(ch_rst), 32'h0);
        check_val("en_274", 32'(ch_en), 32'h2);
        go_to(277);
        check_val("en_277", 32'(ch_en), 32'h2);
        go_to(278);
        div_ratio[31:16] = 16'd5;
        go_to(280);
        check_val("en_280", 32'(ch_en), 32'h3);
        go_to(281);
        div_ratio[15:0] = 16'd0;
        go_to(283);
        check_val("en_283", 32'(ch_en), 32'h0);
        go_to(285);
        check_val("en_285", 32'(ch_en), 32'h3);
        go_to(286);
        check_val("en_286", 32'(ch_en), 32'h1);
        go_to(290);
        check_val("en_290", 32'(ch_en), 32'h3);

        // Lock loss in RUN.
        go_to(300);
        pll_locked = 1'b0;
        go_to(302);
        check_val("loss_locked_d", 32'(locked), 32'd1);
        go_to(303);
        check_val("loss_locked", 32'(locked), 32'd0);
        check_val("loss_ch_rst", 32'(ch_rst), 32'h3);
        check_val("loss_ch_en", 32'(ch_en), 32'h0);
        check_val("loss_flag", 32'(lock_lost), 32'd1);
        check_val("loss_count1", 32'(loss_count), 32'd1);

        // Relock with a one-cycle dropout after 100 cycles: filter restarts.
        go_to(310);
        pll_locked = 1'b1;
        go_to(410);
        pll_locked = 1'b0;
        go_to(411);
        pll_locked = 1'b1;
        go_to(500);
        check_val("blip_locked", 32'(locked), 32'd0);
        check_val("blip_flag", 32'(lock_lost), 32'd1);
        check_val("blip_count", 32'(loss_count), 32'd1);
        go_to(568);
        check_val("no_early_lock", 32'(locked), 32'd0);
        go_to(668);
        check_val("relock_before", 32'(locked), 32'd0);
        go_to(669);
        check_val("relock_T", 32'(locked), 32'd1);
        check_val("relock_ch_rst", 32'(ch_rst), 32'h2);

        // Reset in the middle of RELEASE.
        go_to(674);
        rst = 1'b1;
        go_to(675);
        check_val("mid_rst_locked", 32'(locked), 32'd0);
        check_val("mid_rst_ch_rst", 32'(ch_rst), 32'h3);
        check_val("mid_rst_ch_en", 32'(ch_en), 32'h0);
        check_val("mid_rst_flag", 32'(lock_lost), 32'd0);
        check_val("mid_rst_count", 32'(loss_count), 32'd0);
        rst        = 1'b0;
        pll_locked = 1'b0;

        // Single-channel instance, LOCK_FILTER=2.
        b    = cyc;
        pll2 = 1'b1;
        go_to(b + 3);
        check_val("d2_locked_before", 32'(locked2), 32'd0);
        go_to(b + 4);
        check_val("d2_locked", 32'(locked2), 32'd1);
        check_val("d2_ch_rst", 32'(ch_rst2), 32'd0);
        check_val("d2_ch_en", 32'(ch_en2), 32'd1);
        go_to(b + 6);
        check_val("d2_ch_en_cont", 32'(ch_en2), 32'd1);
        go_to(b + 10);
        pll2 = 1'b0;
        go_to(b + 12);
        check_val("d2_loss_d", 32'(locked2), 32'd1);
        go_to(b + 13);
        check_val("d2_loss_locked", 32'(locked2), 32'd0);
        check_val("d2_loss_flag", 32'(lock_lost2), 32'd1);
        check_val("d2_loss_cnt", 32'(loss2), 32'd1);
        clr2 = 1'b1;
        go_to(b + 14);
        check_val("d2_clr", 32'(lock_lost2), 32'd0);
        clr2 = 1'b0;
        go_to(b + 16);
        pll2 = 1'b1;
        go_to(b + 20);
        check_val("d2_relock", 32'(locked2), 32'd1);
        go_to(b + 24);
        pll2 = 1'b0;
        go_to(b + 26);
        clr2 = 1'b1;
        go_to(b + 27);
        check_val("d2_set_wins", 32'(lock_lost2), 32'd1);
        check_val("d2_loss_cnt2", 32'(loss2), 32'd2);
        clr2 = 1'b0;

        for (int i = 0; i < 258; i++) begin
            pll2 = 1'b1;
            step(8);
            pll2 = 1'b0;
            step(4);
            if (i == 252) begin
                check_val("d2_cnt_255", 32'(loss2), 32'd255);
            end
        end
        check_val("d2_cnt_sat", 32'(loss2), 32'd255);
        check_val("d2_flag_end", 32'(lock_lost2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
